board_update_sequencer: RTL
===========================

# board_update_sequencer

Sequences all writes into the 64-square board store (4 bits per square) and arbitrates between the two producers that modify it: the player-move path and the new-game setup loader. Each accepted request becomes a fixed, registered series of single-square writes: normal, castle, en-passant, promotion, or a full 64-square initial load. The block also owns the side-to-move flag, which it flips when each completed move finishes. It sits between the user-input state machine and the board-build memory, and is that memory's only writer.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- init_req  in  1  one-cycle pulse: load starting position
- mv_valid  in  1  move request valid
- mv_ready  out  1  move request accepted when mv_valid && mv_ready
- mv_from  in  6  source square {col[2:0], row[2:0]}
- mv_to  in  6  destination square, same encoding
- mv_piece  in  4  moving piece {color, type[2:0]}; color 0 = white
- mv_kind  in  2  0 normal, 1 castle, 2 promote-to-queen, 3 en passant
- wr_en  out  1  board write strobe
- wr_addr  out  6  square being written
- wr_data  out  4  new square content
- busy  out  1  sequence in progress or init pending
- done  out  1  one-cycle pulse after the last write of any sequence
- player_turn  out  1  side to move; 0 white, 1 black

## Operation
- Piece types: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king. White pieces start on rows 6–7 and black pieces on rows 0–1.
- States: IDLE, INIT, MOVE, DONE.
- In IDLE:
  - init_pending has priority over a move.
  - mv_ready = (state == IDLE) && !init_pending && !init_req.
- init_req handling:
  - An init_req seen in any state sets init_pending.
  - IDLE with init_pending goes to INIT and clears init_pending.
- INIT: 64 writes, wr_addr 0..63 ascending, with wr_data derived from the address.
  - Row 0: black back rank. By column 0..7: 4, 2, 3, 5, 6, 3, 2, 4, each with color bit 1.
  - Row 1: 4'b1001.
  - Row 6: 4'b0001.
  - Row 7: white back rank, same column order, color bit 0.
  - All other rows: 0.
  - At DONE, player_turn is forced to 0.
- MOVE: the request fields are latched at accept, and the write list depends on mv_kind:
  - Normal: (to, piece), then (from, 0).
  - Promote: (to, {piece[3], 3'd5}), then (from, 0).
  - En passant: (to, piece), then (from, 0), then ({to[5:3], from[2:0]}, 0).
  - Castle, king side (to[5:3] == 6): (to, piece), (from, 0), ({3'd5, row}, {c, 3'd4}), ({3'd7, row}, 0).
    - row = from[2:0]; c = piece[3].
  - Castle, queen side (to[5:3] == 2): same pattern, with the rook moving from column 0 to column 3.
  - Castle with any other destination column: treated as a normal move.
  - At DONE, player_turn toggles.
- The block does not check move legality; that is the requester's job.
- An init_req arriving mid-MOVE does not abort the move. The move finishes (including its turn toggle), then INIT runs.

## Timing
- Reset values: state IDLE; wr_en, wr_addr, wr_data, done, busy, player_turn and init_pending all 0.
- All outputs are registered.
- Move accepted at edge T: writes occur on cycles T+1 .. T+n, one per cycle, with wr_en high on each (n = 2, 3 or 4). done is high on cycle T+n+1; the state is IDLE and mv_ready is high again on T+n+2.
- INIT entered at edge T: writes on T+1 .. T+64, done on T+65.
- busy is high from the cycle after accept through the DONE cycle, and whenever init_pending is set.
- wr_addr and wr_data hold their last values when wr_en is 0.
- Back-to-back: a request held valid during DONE is not accepted until IDLE, giving a minimum gap of 2 cycles between sequences.
- init_req and mv_valid asserted in the same IDLE cycle: the move is not accepted and INIT runs first.
- Reset asserted mid-sequence: all outputs return to their reset values immediately, and a partial write list is abandoned.

## Test plan
- Init load: reset, then pulse init_req.
  - Expect 64 writes.
  - addr 0x00 → 4'b1100; addr 0x07 → 4'b0100; addr 0x26 → 4'b0001; addr 0x20 → 4'b1110; addr 0x03 → 0.
  - done at cycle 65; player_turn = 0.
- Normal move: from 0x26, to 0x24, piece 4'b0001, kind 0.
  - Expect writes (0x24, 1), then (0x26, 0).
  - done 3 cycles after accept; player_turn 0→1.
- Castle king side: from 0x27, to 0x37, piece 4'b0110, kind 1.
  - Expect writes (0x37, 6), (0x27, 0), (0x2F, 4), (0x3F, 0) on consecutive cycles.
- Promote and en passant:
  - Promote: from 0x11, to 0x10, piece 4'b0001, kind 2. Expect (0x10, 4'b0101), then (0x11, 0).
  - En passant: from 0x1B, to 0x22, piece 4'b1001, kind 3. Expect a third write (0x23, 0).
- Arbitration: init_req and mv_valid in the same IDLE cycle.
  - Expect INIT first, with mv_ready low throughout.
  - The move is accepted 2 cycles after the INIT done pulse.
  - A second init_req during that move executes after the move's done.
- Reset mid-castle: assert reset after the 2nd write.
  - Expect wr_en = 0, busy = 0, player_turn = 0 immediately, and no further writes.

Source files
------------

// File: rtl/board_update_sequencer.sv
// Sole writer of the 64-square board store: turns init and move requests into
// registered single-square write sequences and owns the side-to-move flag.
module board_update_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic       mv_valid,
  output logic       mv_ready,
  input  logic [5:0] mv_from,
  input  logic [5:0] mv_to,
  input  logic [3:0] mv_piece,
  input  logic [1:0] mv_kind,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [3:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       player_turn
);

  typedef enum logic [1:0] {IDLE, INIT, MOVE, DONE} state_t;

  state_t     state, state_n;
  logic [5:0] step, step_n;
  logic       init_pending, init_pending_n;
  logic       accept;

  logic [5:0] from_q, to_q;
  logic [3:0] piece_q;
  logic [1:0] kind_q;
  logic [5:0] src_from, src_to;
  logic [3:0] src_piece;
  logic [1:0] src_kind;
  logic [1:0] last_step;

  logic       wr_en_n, busy_n, done_n, turn_n;
  logic [5:0] wr_addr_n;
  logic [3:0] wr_data_n;

  function automatic logic [2:0] back_rank(input logic [2:0] col);
    case (col)
      3'd0, 3'd7: return 3'd4;
      3'd1, 3'd6: return 3'd2;
      3'd2, 3'd5: return 3'd3;
      3'd3:       return 3'd5;
      default:    return 3'd6;
    endcase
  endfunction

  function automatic logic [3:0] init_square(input logic [5:0] sq);
    case (sq[2:0])
      3'd0:    return {1'b1, back_rank(sq[5:3])};
      3'd1:    return 4'b1001;
      3'd6:    return 4'b0001;
      3'd7:    return {1'b0, back_rank(sq[5:3])};
      default: return 4'd0;
    endcase
  endfunction

  // Castle only expands to four writes when the king lands on column 2 or 6.
  function automatic logic [1:0] move_last(input logic [5:0] to, input logic [1:0] kind);
    if (kind == 2'd3)
      return 2'd2;
    else if (kind == 2'd1 && (to[5:3] == 3'd6 || to[5:3] == 3'd2))
      return 2'd3;
    else
      return 2'd1;
  endfunction

  function automatic logic [9:0] move_write(input logic [1:0] idx, input logic [5:0] from,
                                            input logic [5:0] to, input logic [3:0] piece,
                                            input logic [1:0] kind);
    logic       ks;
    logic [3:0] to_data;
    ks      = (to[5:3] == 3'd6);
    to_data = (kind == 2'd2) ? {piece[3], 3'd5} : piece;
    case (idx)
      2'd0:    return {to, to_data};
      2'd1:    return {from, 4'd0};
      2'd2:    return (kind == 2'd3) ? {to[5:3], from[2:0], 4'd0}
                                     : {(ks ? 3'd5 : 3'd3), from[2:0], piece[3], 3'd4};
      default: return {(ks ? 3'd7 : 3'd0), from[2:0], 4'd0};
    endcase
  endfunction

  assign mv_ready = (state == IDLE) && !init_pending && !init_req;
  assign accept   = mv_valid && mv_ready;

  // On the accept cycle the first write comes straight from the request ports.
  always_comb begin
    src_from  = accept ? mv_from  : from_q;
    src_to    = accept ? mv_to    : to_q;
    src_piece = accept ? mv_piece : piece_q;
    src_kind  = accept ? mv_kind  : kind_q;
    last_step = move_last(src_to, src_kind);
  end

  always_comb begin
    init_pending_n = init_req || (init_pending && (state != IDLE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      step         <= '0;
      init_pending <= 1'b0;
    end else begin
      state        <= state_n;
      step         <= step_n;
      init_pending <= init_pending_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      from_q  <= mv_from;
      to_q    <= mv_to;
      piece_q <= mv_piece;
      kind_q  <= mv_kind;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    case (state)
      IDLE: begin
        if (init_pending) begin
          state_n = INIT;
          step_n  = '0;
        end else if (accept) begin
          state_n = MOVE;
          step_n  = '0;
        end
      end
      INIT: begin
        if (step == 6'd63) state_n = DONE;
        else               step_n  = step + 6'd1;
      end
      MOVE: begin
        if (step == {4'd0, last_step}) state_n = DONE;
        else                           step_n  = step + 6'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from the next state so each registered write lines up with its step.
  always_comb begin
    wr_en_n   = (state_n == INIT) || (state_n == MOVE);
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    done_n    = (state_n == DONE);
    busy_n    = (state_n != IDLE) || init_pending_n;
    turn_n    = player_turn;
    if (state_n == INIT) begin
      wr_addr_n = step_n;
      wr_data_n = init_square(step_n);
    end else if (state_n == MOVE) begin
      {wr_addr_n, wr_data_n} = move_write(step_n[1:0], src_from, src_to, src_piece, src_kind);
    end
    if (state_n == DONE && state != DONE)
      turn_n = (state == INIT) ? 1'b0 : !player_turn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      player_turn <= 1'b0;
    end else begin
      wr_en       <= wr_en_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      done        <= done_n;
      busy        <= busy_n;
      player_turn <= turn_n;
    end
  end

endmodule
